// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, FSM states and select encodings for the multi-cycle MIPS control
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
    S_RTYPEWB, S_BEQEX, S_BNEEX, S_ADDIEX, S_ANDIEX, S_IMMWB, S_JEX
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_AND   = 2'b11
  } aluop_t;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_main_fsm.sv
// rtl/mc_main_fsm.sv - main control FSM of the multi-cycle MIPS core
module mc_main_fsm
  import mips_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       pcwrite,
  output logic       branch,
  output logic       bne,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal
);

  state_t state, state_next;
  logic   mem_ok;

  assign mem_ok = memready | ~MEM_WAIT_EN;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:   state_next = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_BNE:       state_next = S_BNEEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_ANDI:      state_next = S_ANDIEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_next = S_MEMRD;
        else if (op == OP_SW) state_next = S_MEMWR;
        else                  state_next = S_FETCH;
      end
      S_MEMRD:   state_next = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   state_next = mem_ok ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_RTYPEWB: state_next = S_FETCH;
      S_BEQEX:   state_next = S_FETCH;
      S_BNEEX:   state_next = S_FETCH;
      S_ADDIEX:  state_next = S_IMMWB;
      S_ANDIEX:  state_next = S_IMMWB;
      S_IMMWB:   state_next = S_FETCH;
      S_JEX:     state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // In reset every strobe stays low and the selects show their FETCH values.
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    bne      = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REGB;
    zeroext  = 1'b0;
    pcsrc    = PCSRC_ALU;
    aluop    = ALU_ADD;
    illegal  = 1'b0;
    if (!reset) begin
      alusrcb = SRCB_FOUR;
    end else begin
      case (state)
        S_FETCH: begin
          alusrcb = SRCB_FOUR;
          irwrite = mem_ok;
          pcwrite = mem_ok;
        end
        S_DECODE: begin
          alusrcb = SRCB_BRANCH;
          case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_J: illegal = 1'b0;
            default: illegal = 1'b1;
          endcase
        end
        S_MEMADR, S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = ALU_FUNCT;
        end
        S_RTYPEWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BEQEX, S_BNEEX: begin
          alusrca = 1'b1;
          aluop   = ALU_SUB;
          pcsrc   = PCSRC_ALUOUT;
          branch  = (state == S_BEQEX);
          bne     = (state == S_BNEEX);
        end
        S_ANDIEX: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
          aluop   = ALU_AND;
          zeroext = 1'b1;
        end
        S_IMMWB: regwrite = 1'b1;
        S_JEX: begin
          pcsrc   = PCSRC_JUMP;
          pcwrite = 1'b1;
        end
        default: pcwrite = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_main_fsm.sv
// tb/tb_mc_main_fsm.sv - table-driven directed bench for mc_main_fsm
module tb_mc_main_fsm;
  import mips_pkg::*;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [17:0] exp;
    string       name;
  } vec_t;

  // {pcwrite,branch,bne,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca}_alusrcb_zeroext_pcsrc_aluop_illegal
  localparam logic [17:0] E_FETCH1 = 18'b1001000000_01_0_00_00_0;
  localparam logic [17:0] E_FETCH0 = 18'b0000000000_01_0_00_00_0;
  localparam logic [17:0] E_DEC    = 18'b0000000000_11_0_00_00_0;
  localparam logic [17:0] E_DECILL = 18'b0000000000_11_0_00_00_1;
  localparam logic [17:0] E_MEMADR = 18'b0000000001_10_0_00_00_0;
  localparam logic [17:0] E_MEMRD  = 18'b0000001000_00_0_00_00_0;
  localparam logic [17:0] E_MEMWB  = 18'b0000010100_00_0_00_00_0;
  localparam logic [17:0] E_MEMWR  = 18'b0000101000_00_0_00_00_0;
  localparam logic [17:0] E_RTEX   = 18'b0000000001_00_0_00_10_0;
  localparam logic [17:0] E_RTWB   = 18'b0000010010_00_0_00_00_0;
  localparam logic [17:0] E_BEQ    = 18'b0100000001_00_0_01_01_0;
  localparam logic [17:0] E_BNE    = 18'b0010000001_00_0_01_01_0;
  localparam logic [17:0] E_ANDI   = 18'b0000000001_10_1_00_11_0;
  localparam logic [17:0] E_IMMWB  = 18'b0000010000_00_0_00_00_0;
  localparam logic [17:0] E_JEX    = 18'b1000000000_00_0_10_00_0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       reset2 = 1'b0;
  logic [5:0] op = 6'b0;
  logic       memready = 1'b1;

  logic pcwrite, branch, bne, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca, zeroext, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic pcwrite2, branch2, bne2, irwrite2, memwrite2, regwrite2, iord2, memtoreg2, regdst2, alusrca2, zeroext2, illegal2;
  logic [1:0] alusrcb2, pcsrc2, aluop2;
  logic [17:0] obs, obs2;

  int nvec = 0;
  int nfail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mc_main_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .pcwrite(pcwrite), .branch(branch), .bne(bne), .irwrite(irwrite),
    .memwrite(memwrite), .regwrite(regwrite), .iord(iord), .memtoreg(memtoreg),
    .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext),
    .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal)
  );

  mc_main_fsm #(.MEM_WAIT_EN(1'b0)) dut_nowait (
    .clk(clk), .reset(reset2), .op(op), .memready(memready),
    .pcwrite(pcwrite2), .branch(branch2), .bne(bne2), .irwrite(irwrite2),
    .memwrite(memwrite2), .regwrite(regwrite2), .iord(iord2), .memtoreg(memtoreg2),
    .regdst(regdst2), .alusrca(alusrca2), .alusrcb(alusrcb2), .zeroext(zeroext2),
    .pcsrc(pcsrc2), .aluop(aluop2), .illegal(illegal2)
  );

  assign obs  = {pcwrite, branch, bne, irwrite, memwrite, regwrite, iord, memtoreg,
                 regdst, alusrca, alusrcb, zeroext, pcsrc, aluop, illegal};
  assign obs2 = {pcwrite2, branch2, bne2, irwrite2, memwrite2, regwrite2, iord2, memtoreg2,
                 regdst2, alusrca2, alusrcb2, zeroext2, pcsrc2, aluop2, illegal2};

  task automatic add(input logic r, input logic [5:0] o, input logic m,
                     input logic [17:0] e, input string nm);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [17:0] got, input logic [17:0] e);
    nvec++;
    if (got !== e) begin
      nfail++;
      $display("FAIL %s: got %b expected %b", nm, got, e);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] o, input logic m,
                      input logic [17:0] e, input string nm);
    @(negedge clk);
    reset = r; op = o; memready = m;
    #1;
    check(nm, obs, e);
  endtask

  initial begin
    add(1'b0, OP_LW,   1'b1, E_FETCH0, "reset_forces_strobes_low");
    add(1'b1, OP_LW,   1'b1, E_FETCH1, "lw_fetch");
    add(1'b1, OP_LW,   1'b1, E_DEC,    "lw_decode");
    add(1'b1, OP_LW,   1'b1, E_MEMADR, "lw_memadr");
    add(1'b1, OP_LW,   1'b1, E_MEMRD,  "lw_memrd");
    add(1'b1, OP_LW,   1'b1, E_MEMWB,  "lw_memwb");
    add(1'b1, OP_SW,   1'b1, E_FETCH1, "sw_fetch");
    add(1'b1, OP_SW,   1'b1, E_DEC,    "sw_decode");
    add(1'b1, OP_SW,   1'b1, E_MEMADR, "sw_memadr");
    add(1'b1, OP_SW,   1'b0, E_MEMWR,  "sw_memwr_wait1");
    add(1'b1, OP_SW,   1'b0, E_MEMWR,  "sw_memwr_wait2");
    add(1'b1, OP_SW,   1'b0, E_MEMWR,  "sw_memwr_wait3");
    add(1'b1, OP_SW,   1'b1, E_MEMWR,  "sw_memwr_done");
    add(1'b1, OP_BEQ,  1'b1, E_FETCH1, "beq_fetch");
    add(1'b1, OP_BEQ,  1'b1, E_DEC,    "beq_decode");
    add(1'b1, OP_BEQ,  1'b1, E_BEQ,    "beq_ex");
    add(1'b1, OP_BNE,  1'b1, E_FETCH1, "bne_fetch");
    add(1'b1, OP_BNE,  1'b1, E_DEC,    "bne_decode");
    add(1'b1, OP_BNE,  1'b1, E_BNE,    "bne_ex");
    add(1'b1, OP_RTYPE,1'b1, E_FETCH1, "r_fetch");
    add(1'b1, OP_RTYPE,1'b1, E_DEC,    "r_decode");
    add(1'b1, OP_RTYPE,1'b1, E_RTEX,   "r_ex");
    add(1'b1, OP_RTYPE,1'b1, E_RTWB,   "r_wb");
    add(1'b1, OP_ADDI, 1'b1, E_FETCH1, "addi_fetch");
    add(1'b1, OP_ADDI, 1'b1, E_DEC,    "addi_decode");
    add(1'b1, OP_ADDI, 1'b1, E_MEMADR, "addi_ex");
    add(1'b1, OP_ADDI, 1'b1, E_IMMWB,  "addi_wb");
    add(1'b1, OP_ANDI, 1'b1, E_FETCH1, "andi_fetch");
    add(1'b1, OP_ANDI, 1'b1, E_DEC,    "andi_decode");
    add(1'b1, OP_ANDI, 1'b1, E_ANDI,   "andi_ex");
    add(1'b1, OP_ANDI, 1'b1, E_IMMWB,  "andi_wb");
    add(1'b1, 6'h3f,   1'b1, E_FETCH1, "ill_fetch");
    add(1'b1, 6'h3f,   1'b1, E_DECILL, "ill_decode");
    add(1'b1, OP_J,    1'b1, E_FETCH1, "j_fetch_after_ill");
    add(1'b1, OP_J,    1'b1, E_DEC,    "j_decode");
    add(1'b1, OP_J,    1'b1, E_JEX,    "j_ex");
    add(1'b1, OP_LW,   1'b0, E_FETCH0, "fetch_wait1");
    add(1'b1, OP_LW,   1'b0, E_FETCH0, "fetch_wait2");
    add(1'b1, OP_LW,   1'b1, E_FETCH1, "fetch_ready");
    add(1'b1, OP_LW,   1'b0, E_DEC,    "decode_ignores_mr");
    add(1'b1, OP_LW,   1'b0, E_MEMADR, "memadr_ignores_mr");
    add(1'b1, OP_LW,   1'b0, E_MEMRD,  "memrd_wait");
    add(1'b1, OP_LW,   1'b1, E_MEMRD,  "memrd_ready");
    add(1'b1, OP_LW,   1'b0, E_MEMWB,  "memwb_after_wait");

    foreach (vecs[i]) step(vecs[i].rst, vecs[i].op, vecs[i].mr, vecs[i].exp, vecs[i].name);

    // Reset lands while a store is stalled in MEMWR.
    step(1'b1, OP_SW, 1'b1, E_FETCH1, "rst_sw_fetch");
    step(1'b1, OP_SW, 1'b1, E_DEC,    "rst_sw_decode");
    step(1'b1, OP_SW, 1'b1, E_MEMADR, "rst_sw_memadr");
    step(1'b1, OP_SW, 1'b0, E_MEMWR,  "rst_sw_memwr");
    step(1'b0, OP_SW, 1'b0, E_FETCH0, "rst_aborts_memwrite");
    step(1'b1, OP_SW, 1'b0, E_FETCH0, "rst_fetch_hold1");
    step(1'b1, OP_SW, 1'b0, E_FETCH0, "rst_fetch_hold2");
    step(1'b1, OP_SW, 1'b1, E_FETCH1, "rst_fetch_ready");
    step(1'b1, OP_SW, 1'b1, E_DEC,    "rst_then_decode");

    // Variant without memory wait: memready low must not stall.
    @(negedge clk);
    reset = 1'b0; reset2 = 1'b1; op = OP_SW; memready = 1'b0;
    #1 check("nowait_fetch", obs2, E_FETCH1);
    @(negedge clk); #1 check("nowait_decode", obs2, E_DEC);
    @(negedge clk); #1 check("nowait_memadr", obs2, E_MEMADR);
    @(negedge clk); #1 check("nowait_memwr", obs2, E_MEMWR);
    @(negedge clk); #1 check("nowait_back_to_fetch", obs2, E_FETCH1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
